seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle 32-bit integer divider for the processor's arithmetic unit, built on one-bit-per-cycle restoring shift-subtract. It is the inverse of the add/subtract datapath: each iteration performs a trial subtraction through the team's ripple-carry adder. It sits beside the combinational ALU and is started by the execute stage. The stage stalls on `busy` and captures results on `done`.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is verified.
- `clk`  input  1  clock. All state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a division. Sampled only in IDLE.
- `is_signed`  input  1  1 selects signed (two's complement), 0 selects unsigned. Captured with `start`.
- `dividend`  input  WIDTH  numerator. Captured with `start`.
- `divisor`  input  WIDTH  denominator. Captured with `start`.
- `busy`  output  1  high from the cycle after `start` is accepted through the cycle `done` is high.
- `done`  output  1  one-cycle pulse. Results are valid in this cycle.
- `quotient`  output  WIDTH  result quotient. Held until the next accepted `start`.
- `remainder`  output  WIDTH  result remainder. Held until the next accepted `start`.
- `div_by_zero`  output  1  flag for the last operation. Valid with `done` and held afterwards.

## Operation
- Reset values: state IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0; iteration counter=0.
- States and transitions:
  - IDLE → RUN on `start`; IDLE → DONE on `start` with `divisor`=0.
  - RUN → FIX after 32 iterations.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- On accept, the block latches magnitudes:
  - `|dividend|` when signed and negative, otherwise the raw value. Same rule for `|divisor|`.
  - `neg_q` = sign(dividend) XOR sign(divisor), signed mode only.
  - `neg_r` = sign(dividend), signed mode only.
- RUN, one iteration per cycle:
  - Shift {R,Q} left by 1.
  - Trial difference T = R − D, computed as R + ~D + 1.
  - If there is no borrow: R ← T and Q[0] ← 1. Otherwise R is kept and Q[0] ← 0.
- FIX: quotient ← neg_q ? −Q : Q; remainder ← neg_r ? −R : R.
- Divide by zero: quotient = 32'hFFFF_FFFF, remainder = dividend (raw), `div_by_zero`=1. The RUN state is skipped.
- Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF: quotient = 32'h8000_0000, remainder = 0, `div_by_zero`=0. This falls out of unsigned 32-bit magnitudes; no special case is needed.
- Results satisfy dividend = quotient·divisor + remainder, with |remainder| < |divisor| and the remainder's sign equal to the dividend's sign (truncating division).

## Timing
- `start` is accepted at edge E0. State is RUN and `busy`=1 during cycles E0+1 … E0+32. FIX runs in E0+33. DONE runs in E0+34 with `done`=1.
- Latency from accept to `done` is 34 cycles, fixed regardless of operand values.
- Divide by zero: DONE occurs in E0+1, so latency is 1 cycle.
- `start` while not IDLE is ignored. This includes the DONE cycle; the next `start` is accepted at the earliest in the cycle after `done`.
- Operand inputs may change after E0 with no effect.
- `reset` mid-operation: immediate return to the reset values. No `done` pulse is generated for the aborted operation.
- `quotient`/`remainder` change only in FIX or in the divide-by-zero accept cycle.

## Structure
- Shared package holds:
  - `WIDTH`=32.
  - The state enum IDLE/RUN/FIX/DONE, encoded 2'b00/01/10/11.
  - The iteration count 32.
  - The divide-by-zero quotient constant.
- One sub-module: `ripple_carry_adder` (existing), instantiated once for the trial subtraction. It takes R, ~D and carry-in 1; the carry-out is the no-borrow indicator.
- Negations in IDLE and FIX use a local two's-complement expression and do not instantiate a second adder.

## Test plan
- Unsigned 100 / 7 → `done` exactly 34 cycles after accept; quotient 14, remainder 2, `div_by_zero`=0.
- Signed −100 / 7 (32'hFFFF_FF9C, 7) → quotient 32'hFFFF_FFF2 (−14), remainder 32'hFFFF_FFFE (−2). Also signed 100 / −7 → −14, 2.
- 32'h1234_5678 / 0 in either mode → `done` 1 cycle after accept; quotient 32'hFFFF_FFFF, remainder 32'h1234_5678, `div_by_zero`=1.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF → quotient 32'h8000_0000, remainder 0. Unsigned 32'hFFFF_FFFF / 1 → quotient 32'hFFFF_FFFF, remainder 0.
- `start` pulsed during RUN with different operands → ignored; the original result is returned and there is exactly one `done`.
- `reset` asserted at cycle 10 of RUN → `busy`=0 asynchronously and outputs return to 0. A new `start` (9 / 3) then yields quotient 3 and remainder 0 after 34 cycles.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package seq_divider_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder; the divider feeds it R, ~D and carry-in 1 for trial subtraction.
module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_divider.sv
// One-bit-per-cycle restoring divider, signed or unsigned, with truncating remainder semantics.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = seq_divider_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state;
    logic [5:0]       count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] den;
    logic             neg_q;
    logic             neg_r;

    logic             neg_dd;
    logic             neg_dv;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             unused_top;

    assign neg_dd     = is_signed & dividend[WIDTH-1];
    assign neg_dv     = is_signed & divisor[WIDTH-1];
    // The shifted partial remainder can exceed WIDTH bits, so the trial subtract is one bit wider.
    assign shifted    = {rem, quo[WIDTH-1]};
    assign unused_top = diff[WIDTH];

    ripple_carry_adder #(.WIDTH(WIDTH + 1)) u_trial_sub (
        .a    (shifted),
        .b    (~{1'b0, den}),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            den         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        count <= '0;
                        rem   <= '0;
                        quo   <= neg_dd ? negate(dividend) : dividend;
                        den   <= neg_dv ? negate(divisor) : divisor;
                        neg_q <= neg_dd ^ neg_dv;
                        neg_r <= neg_dd;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= DIV0_QUOTIENT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= RUN;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem   <= no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], no_borrow};
                    count <= count + 6'd1;
                    if (count == 6'(ITERATIONS - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= neg_q ? negate(quo) : quo;
                    remainder <= neg_r ? negate(rem) : rem;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: reference results queued at accept, compared on each done pulse.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   cyc      = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.acc = 0;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.dz = 1'b0; e.lat = 34;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000; e.r = 32'd0;
            end else if (sgn) begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                check("busy_with_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        e        = model(sgn, a, b);
        e.acc    = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int n0);
        int i = 0;
        while (n_done == n0 && i < 100) begin
            @(posedge clk);
            i++;
        end
        check("done_timeout", (n_done != n0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int n0 = n_done;
        issue(sgn, a, b);
        wait_done(n0);
    endtask

    initial begin
        int n0;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk) reset = 1'b0;

        n0 = n_done;
        issue(1'b0, 32'd100, 32'd7);
        check("busy_run", {31'd0, busy}, 32'd1);
        wait_done(n0);

        run_op(1'b1, 32'hFFFF_FF9C, 32'd7);
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9);
        run_op(1'b1, 32'h1234_5678, 32'd0);
        run_op(1'b0, 32'h1234_5678, 32'd0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FF9C);
        for (int k = 0; k < 6; k++) begin
            run_op(k[0], $urandom, (k < 3) ? 32'($urandom_range(1, 1000)) : $urandom);
        end

        n0 = n_done;
        issue(1'b0, 32'd1000, 32'd9);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 32'd55; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(n0);
        repeat (40) @(posedge clk);
        #1;
        check("single_done", 32'(n_done - n0), 32'd1);
        check("held_quotient", quotient, 32'd111);
        check("idle_busy", {31'd0, busy}, 32'd0);

        issue(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_quotient", quotient, 32'd0);
        check("arst_remainder", remainder, 32'd0);
        sb.delete();
        @(negedge clk) reset = 1'b0;
        n0 = n_done;
        repeat (50) @(posedge clk);
        #1;
        check("no_done_after_abort", 32'(n_done - n0), 32'd0);

        run_op(1'b0, 32'd9, 32'd3);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
